trace_nop_event_extractor: RTL and testbench
============================================

// Module: trace_nop_event_extractor
//
// PURPOSE
// Per-core consumer of the mor1kx_trace_exec stream from a compute tile. Decodes
// l.nop simulation hooks (exit, report, putc), pairs each with the core's shadowed
// r3 value, queues the resulting events in a small FIFO and presents them on a
// valid/ready stream for host-side logging or debug forwarding. Also raises a sticky
// termination flag; one instance per core sits directly downstream of the tile.
//
// PARAMETERS
// ID          0   core index, driven unchanged on evt_core
// FIFO_DEPTH  4   event FIFO entries; power of two, >= 2
// ENABLE_PUTC 1   0: putc hooks are decoded but never queued
//
// PORTS
// clk          in   1   system clock
// rst          in   1   reset, asynchronous, active-high
// trace_valid  in   1   one instruction retired this cycle
// trace_insn   in   32  retired instruction word
// trace_wben   in   1   register write-back enable
// trace_wbreg  in   5   write-back register index
// trace_wbdata in   32  write-back data
// evt_valid    out  1   event available
// evt_ready    in   1   consumer accepts the event
// evt_type     out  2   1 = EXIT, 2 = REPORT, 3 = PUTC
// evt_core     out  16  ID
// evt_data     out  32  r3 value at hook retirement (PUTC: char in [7:0])
// term         out  1   sticky; EXIT has been seen
// drop_cnt     out  16  events lost on a full FIFO; saturates at 16'hFFFF
//
// BEHAVIOUR
// - Reset: r3 shadow = 0, FIFO empty, evt_valid = 0, evt_type/evt_data = 0,
//   term = 0, drop_cnt = 0.
// - Shadow r3: updated when trace_valid & trace_wben & trace_wbreg == 3.
// - Hook decode: trace_valid & insn[31:24] == 8'h15.
//   K = insn[15:0]: 1 = EXIT, 2 = REPORT, 4 = PUTC; every other K is ignored.
// - Hook data: the shadow value registered before this cycle. l.nop writes no
//   register, so no same-cycle forwarding is needed.
// - Latency: event is on evt_valid the cycle after the hook's trace_valid.
// - FIFO: show-ahead. Pop when evt_valid & evt_ready.
// - Simultaneous push and pop while full: the push succeeds, nothing is dropped.
// - Push on full without pop: event discarded and drop_cnt incremented.
//   Exception: EXIT overwrites the youngest entry, so EXIT is never lost and
//   drop_cnt is still incremented.
// - term: set the cycle after an EXIT decode. After term is set:
//   - new hooks are ignored, and drop_cnt does not count them;
//   - already-queued events still drain.
// - evt_* outputs hold stable while evt_valid & !evt_ready.
// - FIFO pointers carry one extra wrap bit; full = MSBs differ and indices equal.
// - rst asserted mid-operation flushes the FIFO and clears term and drop_cnt at once.
//
// STRUCTURE
// - optimsoc_trace package: enum trace_evt_t {EVT_EXIT = 1, EVT_REPORT = 2,
//   EVT_PUTC = 3}, the NOP_* K constants, and struct trace_evt_s {type, data}.
// - Sub-module trace_evt_fifo: parameterized show-ahead FIFO with an overwrite-tail
//   input used for EXIT.
// - Top level: shadow register, decoder, drop counter, term flag.
//
// TESTING
// 1. r3 <- 32'h41 via write-back, then insn 32'h15000004 -> one cycle later
//    evt_valid = 1, type 3, data 32'h41.
// 2. Five REPORT hooks, evt_ready = 0, FIFO_DEPTH = 4 -> four entries queued in
//    order, drop_cnt = 1.
// 3. Full FIFO, evt_ready = 0, then EXIT with r3 = 7 -> last entry becomes EXIT/7,
//    term = 1 the next cycle, drop_cnt incremented.
// 4. After term, PUTC hooks plus evt_ready = 1 -> only pre-term events drain;
//    drop_cnt unchanged.
// 5. FIFO full, same-cycle hook and pop -> no drop; order preserved across pointer
//    wrap over 3 * FIFO_DEPTH events.
// 6. rst pulsed while three entries are queued -> evt_valid = 0 and term = 0
//    immediately; a PUTC after release is delivered normally.

Source files
------------

// File: rtl/trace_nop_event_extractor_pkg.sv
// Shared types and constants for the l.nop trace hook extractor.
package optimsoc_trace;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CORE_W = 16;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 16;

    localparam logic [7:0]       NOP_OPCODE = 8'h15;
    localparam logic [15:0]      NOP_EXIT   = 16'h0001;
    localparam logic [15:0]      NOP_REPORT = 16'h0002;
    localparam logic [15:0]      NOP_PUTC   = 16'h0004;
    localparam logic [REG_W-1:0] REG_R3     = 5'd3;

    typedef enum logic [1:0] {
        EVT_NONE   = 2'd0,
        EVT_EXIT   = 2'd1,
        EVT_REPORT = 2'd2,
        EVT_PUTC   = 2'd3
    } trace_evt_t;

    typedef struct packed {
        trace_evt_t        evt_type;
        logic [DATA_W-1:0] data;
    } trace_evt_s;

endpackage

// File: rtl/trace_nop_event_extractor_if.sv
// Trace-in / event-out bundle; slave is the extractor, master the surrounding environment.
interface trace_nop_event_extractor_if;
    import optimsoc_trace::*;

    logic              trace_valid;
    logic [31:0]       trace_insn;
    logic              trace_wben;
    logic [REG_W-1:0]  trace_wbreg;
    logic [DATA_W-1:0] trace_wbdata;

    logic              evt_valid;
    logic              evt_ready;
    trace_evt_t        evt_type;
    logic [CORE_W-1:0] evt_core;
    logic [DATA_W-1:0] evt_data;

    modport slave (
        input  trace_valid, trace_insn, trace_wben, trace_wbreg, trace_wbdata, evt_ready,
        output evt_valid, evt_type, evt_core, evt_data
    );

    modport master (
        output trace_valid, trace_insn, trace_wben, trace_wbreg, trace_wbdata, evt_ready,
        input  evt_valid, evt_type, evt_core, evt_data
    );

endinterface

// File: rtl/trace_nop_event_extractor_fifo.sv
// Show-ahead event FIFO; a write on full with overwrite set replaces the youngest entry.
module trace_evt_fifo
    import optimsoc_trace::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       overwrite,
    input  trace_evt_s wr_data,
    input  logic       rd_en,
    output trace_evt_s rd_data,
    output logic       empty,
    output logic       full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] tail_idx_c;
    logic          do_pop_c;
    logic          do_push_c;
    logic          do_ovw_c;
    trace_evt_s    mem [DEPTH];

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop_c   = rd_en && !empty;
    // A same-cycle pop frees the slot, so a push on full still lands.
    assign do_push_c  = wr_en && (!full || do_pop_c);
    assign do_ovw_c   = wr_en && full && !do_pop_c && overwrite;
    assign tail_idx_c = wr_ptr[AW-1:0] - AW'(1);
    assign rd_data    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push_c) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop_c)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end else if (do_ovw_c) begin
            mem[tail_idx_c] <= wr_data;
        end
    end

endmodule

// File: rtl/trace_nop_event_extractor.sv
// Decodes l.nop simulation hooks from a core's retire trace and queues them as events.
module trace_nop_event_extractor
    import optimsoc_trace::*;
#(
    parameter int unsigned ID          = 0,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter bit          ENABLE_PUTC = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    trace_nop_event_extractor_if.slave   bus,
    output logic                         term,
    output logic [CNT_W-1:0]             drop_cnt
);

    logic [DATA_W-1:0] r3_q;
    trace_evt_t        hook_type_c;
    logic              push_c;
    logic              pop_c;
    logic              drop_c;
    logic              fifo_empty;
    logic              fifo_full;
    trace_evt_s        wr_evt_c;
    trace_evt_s        rd_evt;
    logic              unused_c;

    assign unused_c = ^bus.trace_insn[23:16];

    // Shadow of r3; hooks sample the value registered before their own cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_q <= '0;
        end else if (bus.trace_valid && bus.trace_wben && (bus.trace_wbreg == REG_R3)) begin
            r3_q <= bus.trace_wbdata;
        end
    end

    always_comb begin
        hook_type_c = EVT_NONE;
        if (bus.trace_valid && (bus.trace_insn[31:24] == NOP_OPCODE) && !term) begin
            case (bus.trace_insn[15:0])
                NOP_EXIT:   hook_type_c = EVT_EXIT;
                NOP_REPORT: hook_type_c = EVT_REPORT;
                NOP_PUTC:   hook_type_c = ENABLE_PUTC ? EVT_PUTC : EVT_NONE;
                default:    hook_type_c = EVT_NONE;
            endcase
        end
    end

    assign push_c   = (hook_type_c != EVT_NONE);
    assign pop_c    = !fifo_empty && bus.evt_ready;
    assign drop_c   = push_c && fifo_full && !pop_c;
    assign wr_evt_c = '{evt_type: hook_type_c, data: r3_q};

    trace_evt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (push_c),
        .overwrite (hook_type_c == EVT_EXIT),
        .wr_data   (wr_evt_c),
        .rd_en     (pop_c),
        .rd_data   (rd_evt),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign bus.evt_valid = !fifo_empty;
    assign bus.evt_type  = rd_evt.evt_type;
    assign bus.evt_data  = rd_evt.data;
    assign bus.evt_core  = CORE_W'(ID);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            term     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (hook_type_c == EVT_EXIT) term <= 1'b1;
            if (drop_c && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_trace_nop_event_extractor.sv
// Randomized and directed bench for trace_nop_event_extractor against a queue-based model.
module tb_trace_nop_event_extractor;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CORE_ID = 16'h00A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        term;
    logic [15:0] drop_cnt;

    trace_nop_event_extractor_if bus ();

    trace_nop_event_extractor #(
        .ID          (CORE_ID),
        .FIFO_DEPTH  (DEPTH),
        .ENABLE_PUTC (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .term     (term),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference state: event queue, shadow r3, sticky exit flag, drop count.
    logic [1:0]  q_t[$];
    logic [31:0] q_d[$];
    logic [31:0] m_r3;
    bit          m_term;
    int          m_drop;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] insn, input bit wben,
                         input logic [4:0] wreg, input logic [31:0] d, input bit rdy);
        bus.trace_valid  = v;
        bus.trace_insn   = insn;
        bus.trace_wben   = wben;
        bus.trace_wbreg  = wreg;
        bus.trace_wbdata = d;
        bus.evt_ready    = rdy;
    endtask

    task automatic model_clear();
        q_t.delete();
        q_d.delete();
        m_r3   = 32'h0;
        m_term = 1'b0;
        m_drop = 0;
    endtask

    // One clock edge of the model, using the inputs the DUT sampled.
    task automatic model_edge();
        bit         pop;
        logic [1:0] et;
        pop = (q_t.size() != 0) && bus.evt_ready;
        et  = 2'd0;
        if (bus.trace_valid && bus.trace_insn[31:24] == 8'h15 && !m_term) begin
            case (bus.trace_insn[15:0])
                16'd1:   et = 2'd1;
                16'd2:   et = 2'd2;
                16'd4:   et = 2'd3;
                default: et = 2'd0;
            endcase
        end
        if (pop) begin
            void'(q_t.pop_front());
            void'(q_d.pop_front());
        end
        if (et != 2'd0) begin
            if (q_t.size() < DEPTH) begin
                q_t.push_back(et);
                q_d.push_back(m_r3);
            end else begin
                if (m_drop < 65535) m_drop++;
                if (et == 2'd1) begin
                    q_t[q_t.size()-1] = et;
                    q_d[q_d.size()-1] = m_r3;
                end
            end
        end
        if (et == 2'd1) m_term = 1'b1;
        if (bus.trace_valid && bus.trace_wben && bus.trace_wbreg == 5'd3) m_r3 = bus.trace_wbdata;
    endtask

    task automatic check_outputs(input string tag);
        bit has;
        has = (q_t.size() != 0);
        check_val({tag, "_valid"}, 32'(bus.evt_valid), 32'(has));
        check_val({tag, "_type"},  32'(bus.evt_type),  has ? 32'(q_t[0]) : 32'h0);
        check_val({tag, "_data"},  bus.evt_data,       has ? q_d[0] : 32'h0);
        check_val({tag, "_term"},  32'(term),          32'(m_term));
        check_val({tag, "_drop"},  32'(drop_cnt),      32'(m_drop));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("cyc");
    endtask

    // Asynchronous reset pulse issued between clock edges.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        check_val("rst_valid", 32'(bus.evt_valid), 32'h0);
        check_val("rst_term",  32'(term),          32'h0);
        check_val("rst_drop",  32'(drop_cnt),      32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int         r;
        logic [31:0] insn;
        logic [15:0] ks[6];
        ks[0] = 16'd0; ks[1] = 16'd2; ks[2] = 16'd3;
        ks[3] = 16'd4; ks[4] = 16'd5; ks[5] = 16'd8;

        rst = 1'b1;
        drive(0, 32'h0, 0, 5'd0, 32'h0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        check_val("core_id", 32'(bus.evt_core), CORE_ID);
        rst = 1'b0;

        // r3 write-back then PUTC hook
        drive(1, 32'h0, 1, 5'd3, 32'h41, 0); tick();
        drive(1, 32'h15000004, 0, 5'd0, 32'h0, 0); tick();
        check_val("t1_valid", 32'(bus.evt_valid), 32'h1);
        check_val("t1_type",  32'(bus.evt_type),  32'h3);
        check_val("t1_data",  bus.evt_data,       32'h41);
        drive(0, 32'h0, 0, 5'd0, 32'h0, 1); tick(); tick();

        // five REPORTs into a four-entry FIFO with no consumer
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h15000002, 1, 5'd3, 32'(100 + i), 0);
            tick();
        end
        check_val("t2_drop", 32'(drop_cnt), 32'h1);
        check_val("t2_type", 32'(bus.evt_type), 32'h2);
        check_val("t2_data", bus.evt_data, 32'h41);

        // EXIT on full FIFO overwrites the youngest entry
        drive(1, 32'h0, 1, 5'd3, 32'h7, 0); tick();
        drive(1, 32'h15000001, 0, 5'd0, 32'h0, 0); tick();
        check_val("t3_term", 32'(term), 32'h1);
        check_val("t3_drop", 32'(drop_cnt), 32'h2);

        // post-term hooks ignored while queue drains
        for (int i = 0; i < 6; i++) begin
            drive(1, 32'h15000004, 0, 5'd0, 32'h0, 1);
            tick();
        end
        check_val("t4_valid", 32'(bus.evt_valid), 32'h0);
        check_val("t4_drop",  32'(drop_cnt), 32'h2);
        do_reset();

        // fill, then hook + pop every cycle across pointer wraps
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 32'h15000002, 1, 5'd3, $urandom, 0);
            tick();
        end
        for (int i = 0; i < 3 * DEPTH; i++) begin
            drive(1, 32'h15000002, 1, 5'd3, $urandom, 1);
            tick();
        end
        check_val("t5_drop", 32'(drop_cnt), 32'h0);
        drive(0, 32'h0, 0, 5'd0, 32'h0, 1);
        repeat (DEPTH + 1) tick();

        // reset with three queued, then a normal PUTC
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h15000004, 1, 5'd3, 32'(i + 1), 0);
            tick();
        end
        do_reset();
        drive(1, 32'h0, 1, 5'd3, 32'h5A, 0); tick();
        drive(1, 32'h15000004, 0, 5'd0, 32'h0, 0); tick();
        check_val("t6_valid", 32'(bus.evt_valid), 32'h1);
        check_val("t6_type",  32'(bus.evt_type),  32'h3);
        check_val("t6_data",  bus.evt_data,       32'h5A);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 2)       insn = 32'h15000001;
            else if (r < 40) insn = {8'h15, 8'($urandom), ks[$urandom_range(0, 5)]};
            else             insn = $urandom;
            drive($urandom_range(0, 3) != 0, insn, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0);
            tick();
            if (m_term && $urandom_range(0, 29) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
